bus_latch_fifo: RTL

Parametrised successor to the octal transparent bus latch: a clocked WIDTH-bit, DEPTH-entry first-word-fall-through buffer with active-low strobes and a tri-state output bus. It sits between a producing bus and a shared tri-state bus, holding several words where a single latch would drop them. Status flags and sticky error bits support bus arbitration and debug.

---
 rtl/bus_latch_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/bus_latch_fifo.sv
// rtl/bus_latch_fifo.sv - FWFT bus latch FIFO with active-low strobes, tri-state dout and sticky ovf/unf
// Optional TRANSPARENT_BYPASS_EN: empty queue passes din straight to dout while wr_n is low.
module bus_latch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_n,
   input  logic             rd_n,
   input  logic             oenb_n,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic             ovf,
   output logic             unf
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_empty;
   logic             r_ovf;
   logic             r_unf;

   logic             w_rd;
   logic             w_wr;
   logic [CW-1:0]    w_count_nxt;
   logic [WIDTH-1:0] w_head;

   // A write into a full queue is accepted only when the same edge frees a slot.
   assign w_rd = !rd_n && !r_empty;
   assign w_wr = !wr_n && (!r_full || w_rd);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr, w_rd})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
         if (!wr_n && r_full && !w_rd) begin
            r_ovf <= 1'b1;
         end
         if (!rd_n && r_empty) begin
            r_unf <= 1'b1;
         end
      end
   end

`ifdef TRANSPARENT_BYPASS_EN
   assign w_head = r_empty ? (!wr_n ? din : '0) : r_mem[r_rd_ptr];
`else
   assign w_head = r_empty ? '0 : r_mem[r_rd_ptr];
`endif

   assign dout  = oenb_n ? 'z : w_head;
   assign full  = r_full;
   assign empty = r_empty;
   assign count = r_count;
   assign ovf   = r_ovf;
   assign unf   = r_unf;

endmodule
